// File: rtl/serial_tx_if.sv
// Byte-producer to serial transmitter link: start strobe, data word,
// and the registered serial line / busy indication coming back.
interface serial_tx_if #(
  parameter int unsigned Width = 8
);
  logic             ce;
  logic [Width-1:0] data;
  logic             tx;
  logic             busy;

  // Core side: issues start strobes and words, watches busy/tx.
  modport master (
    output ce,
    output data,
    input  tx,
    input  busy
  );

  // Transmitter side: consumes strobes and words, drives the line.
  modport slave (
    input  ce,
    input  data,
    output tx,
    output busy
  );
endinterface

// File: rtl/serial_tx.sv
// UART-style serial transmitter: start bit, Width data bits LSB first,
// stop bit; each bit lasts 2^TimerWidth clocks. tx and busy are flops.
module serial_tx #(
  parameter int unsigned Width      = 8,
  parameter int unsigned TimerWidth = 2
) (
  input  logic       clk,
  input  logic       rst,
  serial_tx_if.slave bus
);

  localparam int unsigned IdxWidth = (Width > 1) ? $clog2(Width) : 1;
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(Width - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [TimerWidth-1:0] timer_q, timer_d;
  logic [IdxWidth-1:0]   idx_q,   idx_d;
  logic [Width-1:0]      shreg_q, shreg_d;
  logic                  tx_q,    tx_d;
  logic                  busy_q,  busy_d;
  logic [Width-1:0]      shifted;
  logic                  bit_end;

  // Next-state logic. tx/busy are computed for the following cycle so the
  // line and busy change on the very edge a state transition happens.
  // The word is shifted right at each data-bit boundary, so the bit on the
  // line is always shreg[0]; idx only tracks which bit is the last one.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    shifted = shreg_q >> 1;
    bit_end = (timer_q == '1);

    if (busy_q) begin
      timer_d = timer_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.ce) begin
          shreg_d = bus.data;
          timer_d = '0;
          idx_d   = '0;
          state_d = StStart;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      StStart: begin
        if (bit_end) begin
          state_d = StData;
          idx_d   = '0;
          tx_d    = shreg_q[0];
        end
      end

      StData: begin
        if (bit_end) begin
          if (idx_q == LastIdx) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            shreg_d = shifted;
            tx_d    = shifted[0];
          end
        end
      end

      StStop: begin
        if (bit_end) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          tx_d    = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset abandons any frame and idles the line at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      timer_q <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: stimulus pushes expected frames, one
// monitor per DUT decodes the line slot by slot and compares.
module tb_serial_tx;

  typedef struct {
    logic [7:0] d;
    bit         abort;
    bit         b2b;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  exp_t q0[$];
  exp_t q1[$];

  serial_tx_if #(.Width(8)) bus0 ();
  serial_tx_if #(.Width(5)) bus1 ();

  serial_tx #(.Width(8), .TimerWidth(2)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  serial_tx #(.Width(5), .TimerWidth(3)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  logic [1:0] tx_w;
  logic [1:0] busy_w;
  assign tx_w   = {bus1.tx,   bus0.tx};
  assign busy_w = {bus1.busy, bus0.busy};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok, input int act, input int req);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input int k, input logic [7:0] d, input bit ab, input bit b2b);
    exp_t e;
    e.d = d;
    e.abort = ab;
    e.b2b = b2b;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Decodes one DUT's frames: samples 2 time units after every rising edge.
  task automatic monitor(input int k, input int w, input int per);
    logic prev;
    exp_t e;
    logic expb;
    bit   bad;
    bit   dead;
    bit   have;
    int   fall_cyc;
    prev = 1'b0;
    fall_cyc = -100;
    forever begin
      @(posedge clk); #2;
      if (!rst && busy_w[k] === 1'b1 && prev == 1'b0) begin
        have = (k == 0) ? (q0.size() != 0) : (q1.size() != 0);
        if (!have) begin
          check($sformatf("dut%0d_unexpected_frame", k), 1'b0, 1, 0);
          e.d = '0; e.abort = 1'b0; e.b2b = 1'b0;
        end else if (k == 0) begin
          e = q0.pop_front();
        end else begin
          e = q1.pop_front();
        end
        if (e.b2b)
          check($sformatf("dut%0d_b2b_gap", k), (cyc - fall_cyc) == 1, cyc - fall_cyc, 1);
        dead = 1'b0;
        for (int s = 0; s < w + 2; s++) begin
          expb = (s == 0) ? 1'b0 : (s == w + 1) ? 1'b1 : e.d[s-1];
          bad = 1'b0;
          for (int j = 0; j < per; j++) begin
            if (s != 0 || j != 0) begin
              @(posedge clk); #2;
            end
            if (rst) begin
              dead = 1'b1;
              break;
            end
            if (tx_w[k] !== expb || busy_w[k] !== 1'b1) bad = 1'b1;
          end
          if (dead) break;
          check($sformatf("dut%0d_slot%0d", k, s), !bad, int'(tx_w[k]), int'(expb));
        end
        if (dead) begin
          check($sformatf("dut%0d_abort_expected", k), e.abort, 0, 1);
          check($sformatf("dut%0d_abort_idle", k),
                tx_w[k] === 1'b1 && busy_w[k] === 1'b0,
                int'({tx_w[k], busy_w[k]}), 2);
        end else begin
          check($sformatf("dut%0d_not_aborted", k), !e.abort, int'(e.abort), 0);
          @(posedge clk); #2;
          check($sformatf("dut%0d_busy_fall", k),
                tx_w[k] === 1'b1 && busy_w[k] === 1'b0,
                int'({tx_w[k], busy_w[k]}), 2);
          fall_cyc = cyc;
        end
      end
      prev = busy_w[k];
    end
  endtask

  initial begin
    fork
      monitor(0, 8, 4);
      monitor(1, 5, 8);
    join_none
  end

  initial begin
    bit bad;
    bit seen;

    rst = 1'b1;
    bus0.ce = 1'b0; bus0.data = '0;
    bus1.ce = 1'b0; bus1.data = '0;

    // Reset and idle
    repeat (3) @(negedge clk);
    check("rst_tx0",   bus0.tx === 1'b1,   int'(bus0.tx),   1);
    check("rst_busy0", bus0.busy === 1'b0, int'(bus0.busy), 0);
    check("rst_tx1",   bus1.tx === 1'b1,   int'(bus1.tx),   1);
    check("rst_busy1", bus1.busy === 1'b0, int'(bus1.busy), 0);
    rst = 1'b0;
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (bus0.tx !== 1'b1 || bus0.busy !== 1'b0) bad = 1'b1;
    end
    check("idle_hold", !bad, int'({bus0.tx, bus0.busy}), 2);

    // Single clean frame 0xA5
    push_exp(0, 8'hA5, 1'b0, 1'b0);
    bus0.ce = 1'b1; bus0.data = 8'hA5;
    @(negedge clk);
    bus0.ce = 1'b0;
    repeat (50) @(negedge clk);

    // 0xA5 again with a ce pulse and data changes during the frame
    push_exp(0, 8'hA5, 1'b0, 1'b0);
    bus0.ce = 1'b1; bus0.data = 8'hA5;
    @(negedge clk);
    bus0.ce = 1'b0; bus0.data = 8'h5A;
    repeat (9) @(negedge clk);
    bus0.ce = 1'b1; bus0.data = 8'h00;
    @(negedge clk);
    bus0.ce = 1'b0; bus0.data = 8'hFF;
    repeat (60) @(negedge clk);

    // Back-to-back with ce held high: 0xFF then 0x00
    push_exp(0, 8'hFF, 1'b0, 1'b0);
    push_exp(0, 8'h00, 1'b0, 1'b1);
    bus0.ce = 1'b1; bus0.data = 8'hFF;
    @(negedge clk);
    bus0.data = 8'h00;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus0.busy === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    check("b2b_first_done", seen, int'(seen), 1);
    @(negedge clk);
    bus0.ce = 1'b0;
    repeat (60) @(negedge clk);

    // Mid-frame reset on 0x3C
    push_exp(0, 8'h3C, 1'b1, 1'b0);
    bus0.ce = 1'b1; bus0.data = 8'h3C;
    @(negedge clk);
    bus0.ce = 1'b0;
    repeat (14) @(negedge clk);
    check("busy_before_rst", bus0.busy === 1'b1, int'(bus0.busy), 1);
    rst = 1'b1;
    #1;
    check("async_rst_tx",   bus0.tx === 1'b1,   int'(bus0.tx),   1);
    check("async_rst_busy", bus0.busy === 1'b0, int'(bus0.busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bus0.tx !== 1'b1 || bus0.busy !== 1'b0) bad = 1'b1;
    end
    check("post_rst_idle", !bad, int'({bus0.tx, bus0.busy}), 2);

    // Width=5, TimerWidth=3 instance: 10011 -> 0,1,1,0,0,1,1
    push_exp(1, 8'h13, 1'b0, 1'b0);
    bus1.ce = 1'b1; bus1.data = 5'b10011;
    @(negedge clk);
    bus1.ce = 1'b0; bus1.data = 5'b01100;
    repeat (70) @(negedge clk);

    check("dut0_frames_outstanding", q0.size() == 0, q0.size(), 0);
    check("dut1_frames_outstanding", q1.size() == 0, q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- Parameterised asynchronous serial (UART-style) transmitter.
- Accepts a Width-bit word on a single-cycle start strobe and shifts it out on one line as: start bit, data bits LSB first, stop bit.
- Bit period is 2^TimerWidth clock cycles.
- Sits between a byte-producing core and the serial output pin; reports busy while a frame is in flight.

Parameters:
- Width, 8, number of data bits per frame.
- TimerWidth, 2, width of the bit-period counter; one bit lasts 2^TimerWidth clocks.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- ce  input  1  start strobe; sampled on rising clk edge.
- data  input  Width  word to transmit; sampled only when a start is accepted.
- tx  output  1  serial line; idle high.
- busy  output  1  high while a frame is being transmitted.

Behaviour:
- Reset (rst=1, asynchronous): tx=1, busy=0, bit timer=0, bit index=0, shift register=0. Reset wins over every other input, including mid-frame; the frame is abandoned and the line returns to idle immediately.
- All outputs are registered; no combinational path from ce/data to tx/busy.
- State machine: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1, busy=0.
  - On a rising edge with ce=1: latch data into the shift register, clear the bit timer, go to START, set busy=1 and tx=0 on that same edge.
- START: tx=0 for exactly 2^TimerWidth cycles, then go to DATA with bit index 0.
- DATA:
  - tx = data bit [index] of the latched word, LSB first; each bit is held 2^TimerWidth cycles.
  - After bit Width-1 completes, go to STOP.
- STOP:
  - tx=1 for 2^TimerWidth cycles.
  - At the end of the period: busy=0, go to IDLE.
- Bit timer:
  - TimerWidth-bit counter, cleared on start acceptance, increments every cycle while busy.
  - A bit boundary occurs when the timer wraps from all-ones to 0.
- Frame length: exactly (Width+2)*2^TimerWidth cycles from the accepting edge to the edge where busy falls. With the defaults this is 40 cycles.
- ce while busy=1 is ignored. It is neither queued nor does it disturb the frame. Changes on data while busy have no effect.
- ce held high continuously: a new frame starts on the first edge where busy=0 (the edge after STOP completes). This gives back-to-back frames with no idle gap beyond the stop bit.
- ce and busy falling on the same edge: the new start is not accepted on that edge (state was still STOP). It is accepted on the next edge if ce is still high.
- Width and TimerWidth are any values ≥1. The bit index is sized ceil(log2(Width)) bits, minimum 1.

Test Plan:
- Reset/idle: assert rst for 3 cycles with ce=0 → tx=1, busy=0; hold ce=0 for 50 cycles → tx stays 1, busy stays 0.
- Single frame, defaults, data=0xA5, ce pulsed 1 cycle:
  - busy=1 and tx=0 on the accepting edge.
  - tx sequence per 4-cycle slot: 0,1,0,1,0,0,1,0,1,1.
  - busy falls exactly 40 cycles after acceptance; tx=1 afterwards.
- Busy-ignore: during the 0xA5 frame, pulse ce with data=0x00 at cycle 10 → frame unchanged; no second frame follows; data changes mid-frame do not alter tx.
- Back-to-back: hold ce=1 with data=0xFF then 0x00 → the second frame starts on the edge after busy falls; the second frame's data bits are all 0; stop bit of the first frame is 4 cycles of 1.
- Mid-frame reset: start frame 0x3C, assert rst at cycle 15 → tx=1 and busy=0 immediately (asynchronously); after release the line stays idle until the next ce.
- Parameter sweep: Width=5, TimerWidth=3, data=5'b10011 → 56-cycle frame; tx slots of 8 cycles each: 0,1,1,0,0,1,1.
